// File: rtl/demux_pkg.sv
// Shared constants, slot state encoding and select-decode helpers for the 1-to-9 buffered demux.
// The optional DEMUX_SEL_ERR_EN behaviour uses sel_in_range() to tell legal selects from illegal ones.
package demux_pkg;

    localparam int NUM_OUT    = 9;
    localparam int SEL_W      = 4;
    localparam int DEFAULT_CH = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic logic sel_in_range(input logic [SEL_W-1:0] sel);
        return sel <= SEL_W'(DEFAULT_CH);
    endfunction

    // Out-of-range selects fold onto the default channel.
    function automatic logic [SEL_W-1:0] route_sel(input logic [SEL_W-1:0] sel);
        return sel_in_range(sel) ? sel : SEL_W'(DEFAULT_CH);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: data register plus FULL flag, loaded by the demux and drained by its consumer.
// The data register keeps its last word after draining and clears only on reset.
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    slot_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // A load wins over a drain: a simultaneous drain and load keeps the slot FULL with the new word.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load_i) begin
            state_d = SLOT_FULL;
            data_d  = data_i;
        end else if ((state_q == SLOT_FULL) && ready_i) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;

endmodule

// File: rtl/demux1x9_buf.sv
// 1-to-9 demultiplexer with a one-entry buffer per output channel and valid/ready handshakes.
// Define DEMUX_SEL_ERR_EN to discard out-of-range selects and raise the sticky sel_err flag;
// otherwise selects 9..15 route to channel 8.
module demux1x9_buf
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_OUT    = 9
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic [SEL_W-1:0]              in_sel,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]            out_valid,
    input  logic [NUM_OUT-1:0]            out_ready,
`ifdef DEMUX_SEL_ERR_EN
    output logic                          sel_err,
`endif
    output logic                          busy
);

    logic [SEL_W-1:0]   ch;
    logic [NUM_OUT-1:0] load;
    logic [NUM_OUT-1:0] slot_valid;
    logic               in_fire;
    logic               route_ok;

    assign ch      = route_sel(in_sel);
    assign in_fire = in_valid && in_ready;

`ifdef DEMUX_SEL_ERR_EN
    logic sel_ok;
    logic sel_err_q, sel_err_d;

    assign sel_ok   = sel_in_range(in_sel);
    assign route_ok = sel_ok;
`else
    assign route_ok = 1'b1;
`endif

    // Ready looks only at the addressed slot, so other channels never stall the input.
    always_comb begin
        in_ready = 1'b0;
        if (RESET_N) begin
            in_ready = !slot_valid[ch] || out_ready[ch];
`ifdef DEMUX_SEL_ERR_EN
            if (!sel_ok) begin
                in_ready = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        load = '0;
        if (in_fire && route_ok) begin
            load[ch] = 1'b1;
        end
    end

`ifdef DEMUX_SEL_ERR_EN
    assign sel_err_d = sel_err_q || (in_fire && !sel_ok);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`endif

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        demux_slot #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_slot (
            .clk_i  (CLK),
            .rst_n_i(RESET_N),
            .load_i (load[k]),
            .data_i (in_data),
            .ready_i(out_ready[k]),
            .valid_o(slot_valid[k]),
            .data_o (out_data[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign out_valid = slot_valid;
    assign busy      = |slot_valid;

endmodule

// File: tb/tb_demux1x9_buf.sv
// Directed and scoreboarded bench for demux1x9_buf; builds with or without DEMUX_SEL_ERR_EN.
module tb_demux1x9_buf;

    localparam int DW = 32;
    localparam int NO = 9;

    logic              CLK = 1'b0;
    logic              RESET_N;
    logic [DW-1:0]     in_data;
    logic [3:0]        in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [NO*DW-1:0]  out_data;
    logic [NO-1:0]     out_valid;
    logic [NO-1:0]     out_ready;
    logic              busy;
`ifdef DEMUX_SEL_ERR_EN
    logic              sel_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sb_q [NO][$];

    always #5 CLK = ~CLK;

    demux1x9_buf #(.DATA_WIDTH(DW), .NUM_OUT(NO)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef DEMUX_SEL_ERR_EN
        .sel_err  (sel_err),
`endif
        .busy     (busy)
    );

    function automatic logic [DW-1:0] word(input int k);
        return out_data[k*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET_N   = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 4'd0;
        in_data   = '0;
        out_ready = '1;
        tick();
        tick();
        checks++;
        if (out_valid !== 9'h000) begin
            errors++; $display("FAIL reset_valid: got %h expected 000", out_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (out_data !== '0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", out_data);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
`ifdef DEMUX_SEL_ERR_EN
        checks++;
        if (sel_err !== 1'b0) begin
            errors++; $display("FAIL reset_sel_err: got %b expected 0", sel_err);
        end
`endif
    endtask

    task automatic test_basic();
        RESET_N  = 1'b1;
        in_sel   = 4'd3;
        in_data  = 32'hDEADBEEF;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_first_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 9'h008) begin
            errors++; $display("FAIL basic_valid: got %h expected 008", out_valid);
        end
        checks++;
        if (word(3) !== 32'hDEADBEEF) begin
            errors++; $display("FAIL basic_data: got %h expected deadbeef", word(3));
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL basic_busy: got %b expected 1", busy);
        end
        tick();
        checks++;
        if (out_valid !== 9'h000) begin
            errors++; $display("FAIL basic_drained: got %h expected 000", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 9'h1DF;
        in_sel    = 4'd5;
        in_data   = 32'h11;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 9'h020 || word(5) !== 32'h11) begin
            errors++; $display("FAIL bp_held: got valid %h data %h expected 020 / 11", out_valid, word(5));
        end
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_ready_ch5: got %b expected 0", in_ready);
        end
        in_sel = 4'd2;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_ready_ch2: got %b expected 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 9'h020 || word(5) !== 32'h11) begin
            errors++; $display("FAIL bp_still_held: got valid %h data %h expected 020 / 11", out_valid, word(5));
        end
        out_ready = '1;
        in_sel    = 4'd5;
        in_data   = 32'h22;
        in_valid  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_pass_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 9'h020 || word(5) !== 32'h22) begin
            errors++; $display("FAIL bp_no_bubble: got valid %h data %h expected 020 / 22", out_valid, word(5));
        end
        tick();
        checks++;
        if (out_valid !== 9'h000 || word(5) !== 32'h22) begin
            errors++; $display("FAIL bp_empty_hold: got valid %h data %h expected 000 / 22", out_valid, word(5));
        end
    endtask

    task automatic test_back_to_back();
        out_ready = '1;
        in_sel    = 4'd0;
        for (int i = 1; i <= 8; i++) begin
            in_data  = 32'(i);
            in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid[0] !== 1'b1 || word(0) !== 32'(i)) begin
                errors++; $display("FAIL b2b_data[%0d]: got valid %b data %h expected 1 / %h", i, out_valid[0], word(0), i);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 9'h000) begin
            errors++; $display("FAIL b2b_drained: got %h expected 000", out_valid);
        end
    endtask

    task automatic test_out_of_range();
        out_ready = '1;
        in_sel    = 4'd12;
        in_data   = 32'hA5;
        in_valid  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL oor_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
`ifdef DEMUX_SEL_ERR_EN
        checks++;
        if (out_valid !== 9'h000) begin
            errors++; $display("FAIL oor_discard: got %h expected 000", out_valid);
        end
        checks++;
        if (sel_err !== 1'b1) begin
            errors++; $display("FAIL oor_sel_err: got %b expected 1", sel_err);
        end
        tick();
        checks++;
        if (sel_err !== 1'b1) begin
            errors++; $display("FAIL oor_sel_err_sticky: got %b expected 1", sel_err);
        end
`else
        checks++;
        if (out_valid !== 9'h100 || word(8) !== 32'hA5) begin
            errors++; $display("FAIL oor_route8: got valid %h data %h expected 100 / a5", out_valid, word(8));
        end
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        out_ready = '0;
        in_valid  = 1'b1;
        in_sel = 4'd1; in_data = 32'h101; tick();
        in_sel = 4'd4; in_data = 32'h404; tick();
        in_sel = 4'd8; in_data = 32'h808; tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 9'h112 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_filled: got valid %h busy %b expected 112 / 1", out_valid, busy);
        end
        RESET_N = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_ready_in_reset: got %b expected 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 9'h000 || busy !== 1'b0 || out_data !== '0) begin
            errors++; $display("FAIL mid_cleared: got valid %h busy %b data %h expected 000 / 0 / 0", out_valid, busy, out_data);
        end
`ifdef DEMUX_SEL_ERR_EN
        checks++;
        if (sel_err !== 1'b0) begin
            errors++; $display("FAIL mid_sel_err: got %b expected 0", sel_err);
        end
`endif
        RESET_N   = 1'b1;
        out_ready = '1;
        in_sel    = 4'd2;
        in_data   = 32'h77;
        in_valid  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_first_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 9'h004 || word(2) !== 32'h77) begin
            errors++; $display("FAIL mid_deliver: got valid %h data %h expected 004 / 77", out_valid, word(2));
        end
        tick();
        checks++;
        if (out_valid !== 9'h000) begin
            errors++; $display("FAIL mid_drained: got %h expected 000", out_valid);
        end
    endtask

    task automatic test_random();
        int ch;
        logic exp_ready;
        logic in_range;
        for (int cyc = 0; cyc < 10020; cyc++) begin
            if (cyc < 10000) begin
                in_valid = 1'($urandom_range(0, 1));
`ifdef DEMUX_SEL_ERR_EN
                in_sel = 4'($urandom_range(0, 15));
`else
                in_sel = 4'($urandom_range(0, 12));
`endif
                in_data   = $urandom;
                out_ready = 9'($urandom_range(0, 511)) | 9'($urandom_range(0, 511));
            end else begin
                in_valid  = 1'b0;
                out_ready = '1;
            end
            #1;
            in_range = (in_sel <= 4'd8);
            ch = in_range ? int'(in_sel) : 8;
            exp_ready = (sb_q[ch].size() == 0) || out_ready[ch];
`ifdef DEMUX_SEL_ERR_EN
            if (!in_range) exp_ready = 1'b1;
`else
            in_range = 1'b1;
`endif
            checks++;
            if (in_ready !== exp_ready) begin
                errors++; $display("FAIL rnd_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_ready);
            end
            for (int k = 0; k < NO; k++) begin
                checks++;
                if (out_valid[k] !== (sb_q[k].size() != 0)) begin
                    errors++; $display("FAIL rnd_valid cyc %0d ch %0d: got %b expected %b", cyc, k, out_valid[k], sb_q[k].size() != 0);
                end
                if (out_ready[k] && sb_q[k].size() != 0) begin
                    checks++;
                    if (word(k) !== sb_q[k][0]) begin
                        errors++; $display("FAIL rnd_data cyc %0d ch %0d: got %h expected %h", cyc, k, word(k), sb_q[k][0]);
                    end
                    void'(sb_q[k].pop_front());
                end
            end
            if (in_valid && exp_ready && in_range) begin
                sb_q[ch].push_back(in_data);
            end
            tick();
        end
        for (int k = 0; k < NO; k++) begin
            checks++;
            if (sb_q[k].size() != 0 || out_valid[k] !== 1'b0) begin
                errors++; $display("FAIL rnd_leftover ch %0d: got pending %0d valid %b expected 0 / 0", k, sb_q[k].size(), out_valid[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
